conv_tile_scheduler: RTL and testbench
======================================

Name: conv_tile_scheduler

Overview:
- Layer-level controller sequencing the Piy x Pix convolution tile datapath over a full layer.
- Walks output feature maps and output tile positions in order. For each job it fetches weights and pixels from the on-chip buffers and fires the datapath start.
- The datapath then iterates Nif input maps internally. The scheduler waits for its final-accumulation valid, then hands the tile to the output buffer.

Parameters:
- Nif, 10, input feature maps per job; sizes the datapath map sweep and the watchdog limit.
- Nof, 4, output feature maps per layer.
- Nox, 6, output width in pixels; must be a multiple of Pix.
- Noy, 6, output height in pixels; must be a multiple of Piy.
- Pix, 3, tile width.
- Piy, 3, tile height.
- kx, 3, kernel size; sizes the watchdog limit.
- WDOG_SLACK, 64, extra cycles allowed per job beyond Nif*kx*kx.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a layer
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last tile is stored
- wbuf_rd_req  out  1  weight fetch request
- wbuf_of  out  $clog2(Nof)  output map whose weights are fetched
- wbuf_rd_valid  in  1  weights stable on the datapath inputs
- pbuf_rd_req  out  1  pixel fetch request
- pbuf_tx  out  $clog2(Nox/Pix)  tile column
- pbuf_ty  out  $clog2(Noy/Piy)  tile row
- pbuf_rd_valid  in  1  padded pixel window stable
- dp_pixel_ready  out  1  datapath pixel strobe
- dp_weight_ready  out  1  datapath weight strobe
- dp_acc_valid  in  1  datapath final accumulation valid
- obuf_wr_valid  out  1  tile store request
- obuf_wr_ready  in  1  output buffer accepts
- obuf_addr  out  $clog2(Nof*(Nox/Pix)*(Noy/Piy))  tile slot
- err  out  1  sticky protocol/watchdog error

Behaviour:
- Reset values: all outputs 0, all counters 0, FSM in IDLE. Reset mid-layer abandons the job immediately; no done pulse is generated.
- Constants:
  - TX = Nox/Pix
  - TY = Noy/Piy
  - JOBS = Nof*TX*TY
  - obuf_addr = (of*TY + ty)*TX + tx
  - Index arithmetic is unsigned and sized to hold its maximum.
- Job order: tx fastest, then ty, then of. Weights are refetched only when of changes, or on the first job.
- FSM:
  - IDLE: on start go to LOAD_W, assert busy, clear counters.
  - LOAD_W: hold wbuf_rd_req high until wbuf_rd_valid, then go to LOAD_P. Skipped straight to LOAD_P when of is unchanged.
  - LOAD_P: hold pbuf_rd_req high until pbuf_rd_valid, then go to ISSUE.
  - ISSUE: assert dp_pixel_ready and dp_weight_ready for exactly one cycle, clear the watchdog, go to WAIT.
  - WAIT: on dp_acc_valid go to STORE. If the watchdog reaches Nif*kx*kx + WDOG_SLACK, set err and go to STORE anyway.
  - STORE: hold obuf_wr_valid with a stable obuf_addr until obuf_wr_ready, then go to NEXT. Backpressure is unbounded.
  - NEXT: advance tx/ty/of. If that was the last job, go to FIN; otherwise go to LOAD_W or LOAD_P.
  - FIN: pulse done for one cycle, drop busy, go to IDLE.
- Fetch handshake: request level-held, valid sampled each cycle. A valid arriving in the same cycle the request rises is accepted.
- Latency: ISSUE is exactly one cycle after pbuf_rd_valid is sampled. STORE is entered the cycle after dp_acc_valid.
- Boundaries:
  - start while busy is ignored.
  - start coinciding with the done cycle is ignored.
  - dp_acc_valid outside WAIT sets err and is otherwise ignored.
  - wbuf_rd_valid or pbuf_rd_valid without a request is ignored.
  - Counter wrap: tx wraps at TX-1 and increments ty; ty wraps at TY-1 and increments of.
  - err clears only on rst or an accepted start.

Decomposition:
- Package conv_sched_pkg:
  - FSM state enum: IDLE, LOAD_W, LOAD_P, ISSUE, WAIT, STORE, NEXT, FIN.
  - Functions for TX, TY, JOBS and obuf_addr.
- Sub-module tile_index_counter: nested tx/ty/of counter with step, last and of_changed outputs.

Test Plan:
- Defaults, 1-cycle buffer valid, dp_acc_valid 90 cycles after ISSUE -> 16 stores at addresses 0..15 in order, 4 weight fetches (of=0..3), 16 pixel fetches, done pulses once, err=0.
- obuf_wr_ready held low 20 cycles on job 5 -> obuf_wr_valid and obuf_addr=5 stable for 21 cycles, no new ISSUE.
- dp_acc_valid never returns on job 0 -> err=1 after 90+64 cycles, store at addr 0 still occurs, layer completes.
- start pulsed again while busy at job 3 -> no restart, still exactly 16 stores.
- rst asserted during WAIT of job 7 -> all outputs 0 next edge; subsequent start runs a full 16-job layer from addr 0.
- Spurious dp_acc_valid in IDLE -> err=1; next start clears it.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// -----------------------------------------------------------------------------
// conv_sched_pkg
// Shared types and index helpers for the convolution tile scheduler.
//   state_e    : scheduler FSM states
//   idx_w      : index width for a count of n (never below 1 bit)
//   tiles_x/y  : number of tile columns / rows in the output map
//   jobs       : total tile jobs in one layer
//   slot_addr  : output-buffer slot of a (of, ty, tx) tile
// -----------------------------------------------------------------------------
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_P = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    STORE  = 3'd5,
    NEXT   = 3'd6,
    FIN    = 3'd7
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
  endfunction

  function automatic int unsigned tiles_x(input int unsigned nox, input int unsigned pix);
    return nox / pix;
  endfunction

  function automatic int unsigned tiles_y(input int unsigned noy, input int unsigned piy);
    return noy / piy;
  endfunction

  function automatic int unsigned jobs(input int unsigned nof, input int unsigned tx_n,
                                       input int unsigned ty_n);
    return nof * tx_n * ty_n;
  endfunction

  function automatic int unsigned slot_addr(input int unsigned of, input int unsigned ty,
                                            input int unsigned tx, input int unsigned tx_n,
                                            input int unsigned ty_n);
    return (of * ty_n + ty) * tx_n + tx;
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_counter.sv
// -----------------------------------------------------------------------------
// tile_index_counter
// Nested tile position counter: tx fastest, then ty, then of.
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : return all indices to zero (start of a layer)
//   step_i        : advance to the next job
//   tx_o/ty_o/of_o: current tile column, tile row, output map
//   last_o        : current job is the last of the layer
//   of_changed_o  : the next step moves to a new output map
// -----------------------------------------------------------------------------
module tile_index_counter import conv_sched_pkg::*; #(
  parameter int unsigned TX_N = 2,
  parameter int unsigned TY_N = 2,
  parameter int unsigned OF_N = 4,
  localparam int unsigned TX_W = idx_w(TX_N),
  localparam int unsigned TY_W = idx_w(TY_N),
  localparam int unsigned OF_W = idx_w(OF_N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            step_i,
  output logic [TX_W-1:0] tx_o,
  output logic [TY_W-1:0] ty_o,
  output logic [OF_W-1:0] of_o,
  output logic            last_o,
  output logic            of_changed_o
);

  logic [TX_W-1:0] tx_q, tx_d;
  logic [TY_W-1:0] ty_q, ty_d;
  logic [OF_W-1:0] of_q, of_d;
  logic            tx_wrap_s, ty_wrap_s, of_wrap_s;

  assign tx_wrap_s    = (tx_q == TX_W'(TX_N - 32'd1));
  assign ty_wrap_s    = (ty_q == TY_W'(TY_N - 32'd1));
  assign of_wrap_s    = (of_q == OF_W'(OF_N - 32'd1));
  assign last_o       = tx_wrap_s && ty_wrap_s && of_wrap_s;
  assign of_changed_o = tx_wrap_s && ty_wrap_s;
  assign tx_o         = tx_q;
  assign ty_o         = ty_q;
  assign of_o         = of_q;

  // Next-index computation with carry from tx into ty into of.
  always_comb begin
    tx_d = tx_q;
    ty_d = ty_q;
    of_d = of_q;
    if (clear_i) begin
      tx_d = '0;
      ty_d = '0;
      of_d = '0;
    end else if (step_i) begin
      if (tx_wrap_s) begin
        tx_d = '0;
        if (ty_wrap_s) begin
          ty_d = '0;
          if (of_wrap_s) begin
            of_d = '0;
          end else begin
            of_d = of_q + OF_W'(1);
          end
        end else begin
          ty_d = ty_q + TY_W'(1);
        end
      end else begin
        tx_d = tx_q + TX_W'(1);
      end
    end else begin
      tx_d = tx_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q <= '0;
      ty_q <= '0;
      of_q <= '0;
    end else begin
      tx_q <= tx_d;
      ty_q <= ty_d;
      of_q <= of_d;
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// -----------------------------------------------------------------------------
// conv_tile_scheduler
// Layer-level controller for the Piy x Pix convolution tile datapath. Walks
// every (of, ty, tx) tile job, fetches weights (only when of changes) and the
// pixel window, fires the datapath, waits for its final accumulation (with a
// watchdog) and stores the tile into the output buffer.
//   clk, rst                       : clock, asynchronous active-high reset
//   start / busy / done            : layer control and status
//   wbuf_rd_req/of/rd_valid        : weight fetch handshake
//   pbuf_rd_req/tx/ty/rd_valid     : pixel fetch handshake
//   dp_pixel_ready/weight_ready    : one-cycle datapath start strobes
//   dp_acc_valid                   : datapath final accumulation valid
//   obuf_wr_valid/ready/addr       : tile store handshake
//   err                            : sticky protocol / watchdog error
// -----------------------------------------------------------------------------
module conv_tile_scheduler import conv_sched_pkg::*; #(
  parameter int unsigned Nif        = 10,
  parameter int unsigned Nof        = 4,
  parameter int unsigned Nox        = 6,
  parameter int unsigned Noy        = 6,
  parameter int unsigned Pix        = 3,
  parameter int unsigned Piy        = 3,
  parameter int unsigned kx         = 3,
  parameter int unsigned WDOG_SLACK = 64,
  localparam int unsigned TX         = tiles_x(Nox, Pix),
  localparam int unsigned TY         = tiles_y(Noy, Piy),
  localparam int unsigned JOBS       = jobs(Nof, TX, TY),
  localparam int unsigned OF_W       = idx_w(Nof),
  localparam int unsigned TX_W       = idx_w(TX),
  localparam int unsigned TY_W       = idx_w(TY),
  localparam int unsigned ADDR_W     = idx_w(JOBS),
  localparam int unsigned WDOG_LIMIT = Nif * kx * kx + WDOG_SLACK,
  localparam int unsigned WDOG_W     = idx_w(WDOG_LIMIT + 32'd1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wbuf_rd_req,
  output logic [OF_W-1:0]   wbuf_of,
  input  logic              wbuf_rd_valid,
  output logic              pbuf_rd_req,
  output logic [TX_W-1:0]   pbuf_tx,
  output logic [TY_W-1:0]   pbuf_ty,
  input  logic              pbuf_rd_valid,
  output logic              dp_pixel_ready,
  output logic              dp_weight_ready,
  input  logic              dp_acc_valid,
  output logic              obuf_wr_valid,
  input  logic              obuf_wr_ready,
  output logic [ADDR_W-1:0] obuf_addr,
  output logic              err
);

  state_e              state_q;
  logic                busy_q, done_q, wreq_q, preq_q, dp_rdy_q, obuf_valid_q, err_q;
  logic [ADDR_W-1:0]   obuf_addr_q;
  logic [WDOG_W-1:0]   wdog_q;

  logic [TX_W-1:0]     tx_s;
  logic [TY_W-1:0]     ty_s;
  logic [OF_W-1:0]     of_s;
  logic                last_s, of_changed_s;
  logic                start_acc_s, step_s, acc_stray_s;
  logic [ADDR_W-1:0]   addr_s;

  // A start landing on the done cycle (first IDLE cycle) is not accepted.
  assign start_acc_s = start && (state_q == IDLE) && !done_q;
  assign step_s      = (state_q == NEXT);
  assign acc_stray_s = dp_acc_valid && (state_q != WAIT);
  assign addr_s      = ADDR_W'(slot_addr(32'(of_s), 32'(ty_s), 32'(tx_s), TX, TY));

  tile_index_counter #(
    .TX_N (TX),
    .TY_N (TY),
    .OF_N (Nof)
  ) u_idx (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_acc_s),
    .step_i       (step_s),
    .tx_o         (tx_s),
    .ty_o         (ty_s),
    .of_o         (of_s),
    .last_o       (last_s),
    .of_changed_o (of_changed_s)
  );

  // Scheduler FSM; every output is a register set on entry to its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wreq_q       <= 1'b0;
      preq_q       <= 1'b0;
      dp_rdy_q     <= 1'b0;
      obuf_valid_q <= 1'b0;
      obuf_addr_q  <= '0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_acc_s) begin
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            wreq_q  <= 1'b1;
            state_q <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (wbuf_rd_valid) begin
            wreq_q  <= 1'b0;
            preq_q  <= 1'b1;
            state_q <= LOAD_P;
          end
        end
        LOAD_P: begin
          if (pbuf_rd_valid) begin
            preq_q   <= 1'b0;
            dp_rdy_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          dp_rdy_q <= 1'b0;
          wdog_q   <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          // wdog_q counts completed WAIT cycles; the timeout fires on the
          // cycle in which it would reach WDOG_LIMIT.
          if (dp_acc_valid) begin
            obuf_valid_q <= 1'b1;
            obuf_addr_q  <= addr_s;
            state_q      <= STORE;
          end else if (wdog_q == WDOG_W'(WDOG_LIMIT - 32'd1)) begin
            err_q        <= 1'b1;
            obuf_valid_q <= 1'b1;
            obuf_addr_q  <= addr_s;
            state_q      <= STORE;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        STORE: begin
          if (obuf_wr_ready) begin
            obuf_valid_q <= 1'b0;
            state_q      <= NEXT;
          end
        end
        NEXT: begin
          // last_s / of_changed_s describe the job just stored; the counter
          // steps on this same edge.
          if (last_s) begin
            state_q <= FIN;
          end else if (of_changed_s) begin
            wreq_q  <= 1'b1;
            state_q <= LOAD_W;
          end else begin
            preq_q  <= 1'b1;
            state_q <= LOAD_P;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          wreq_q       <= 1'b0;
          preq_q       <= 1'b0;
          dp_rdy_q     <= 1'b0;
          obuf_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
      if (acc_stray_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign wbuf_rd_req     = wreq_q;
  assign wbuf_of         = of_s;
  assign pbuf_rd_req     = preq_q;
  assign pbuf_tx         = tx_s;
  assign pbuf_ty         = ty_s;
  assign dp_pixel_ready  = dp_rdy_q;
  assign dp_weight_ready = dp_rdy_q;
  assign obuf_wr_valid   = obuf_valid_q;
  assign obuf_addr       = obuf_addr_q;
  assign err             = err_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_tile_scheduler
// Directed bench for conv_tile_scheduler with default parameters
// (TX=2, TY=2, Nof=4 -> 16 jobs, watchdog limit 154). Responders drive the
// buffer / datapath / output-buffer inputs at posedge+1; a monitor samples at
// negedge and checks fetches and stores against scoreboard queues that the
// stimulus fills when it starts a layer.
// -----------------------------------------------------------------------------
module tb_conv_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, wbuf_rd_req, pbuf_rd_req, dp_pixel_ready, dp_weight_ready;
  logic       obuf_wr_valid, err;
  logic [1:0] wbuf_of;
  logic [0:0] pbuf_tx, pbuf_ty;
  logic [3:0] obuf_addr;
  logic       wbuf_rd_valid, pbuf_rd_valid, dp_acc_valid, obuf_wr_ready;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_addr_q[$];
  int exp_of_q[$];
  int exp_tile_q[$];

  int acc_delay  = 90;
  int drop_job   = -1;
  int stall_addr = -1;
  int stall_len  = 0;
  logic spur = 1'b0;

  int issue_cnt = 0, wfetch_cnt = 0, pfetch_cnt = 0, store_cnt = 0, done_cnt = 0;
  int overlap_cnt = 0, addr5_run = 0;
  int s_issue, s_done, s_store, s_wf, s_pf, s_ovl;

  conv_tile_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .wbuf_rd_req     (wbuf_rd_req),
    .wbuf_of         (wbuf_of),
    .wbuf_rd_valid   (wbuf_rd_valid),
    .pbuf_rd_req     (pbuf_rd_req),
    .pbuf_tx         (pbuf_tx),
    .pbuf_ty         (pbuf_ty),
    .pbuf_rd_valid   (pbuf_rd_valid),
    .dp_pixel_ready  (dp_pixel_ready),
    .dp_weight_ready (dp_weight_ready),
    .dp_acc_valid    (dp_acc_valid),
    .obuf_wr_valid   (obuf_wr_valid),
    .obuf_wr_ready   (obuf_wr_ready),
    .obuf_addr       (obuf_addr),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] out_vec();
    return {busy, done, wbuf_rd_req, wbuf_of, pbuf_rd_req, pbuf_tx, pbuf_ty,
            dp_pixel_ready, dp_weight_ready, obuf_wr_valid, obuf_addr, err};
  endfunction

  // Weight / pixel buffers: valid for one cycle while the request is held.
  initial begin : buf_drv
    wbuf_rd_valid = 1'b0;
    pbuf_rd_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      wbuf_rd_valid = wbuf_rd_req && !wbuf_rd_valid;
      pbuf_rd_valid = pbuf_rd_req && !pbuf_rd_valid;
    end
  end

  // Datapath: acc_valid acc_delay cycles after the ISSUE cycle, except job drop_job.
  initial begin : dp_drv
    int cnt;
    int job;
    cnt = 0;
    job = 0;
    dp_acc_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      dp_acc_valid = spur;
      if (rst || !busy) begin
        cnt = 0;
        job = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) dp_acc_valid = 1'b1;
        end
        if (dp_pixel_ready) begin
          if (job != drop_job) cnt = acc_delay;
          job++;
        end
      end
    end
  end

  // Output buffer: accepts at once unless stalling on stall_addr.
  initial begin : ob_drv
    int sc;
    sc = 0;
    obuf_wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (obuf_wr_valid && int'(obuf_addr) == stall_addr && sc < stall_len) begin
        obuf_wr_ready = 1'b0;
        sc++;
      end else begin
        obuf_wr_ready = obuf_wr_valid;
        if (!obuf_wr_valid) sc = 0;
      end
    end
  end

  // Monitor: pops scoreboards on every accepted fetch and store.
  initial begin : mon
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) run = 0;
      if (done) done_cnt++;
      if (dp_pixel_ready) begin
        issue_cnt++;
        check("strobes_together", longint'(dp_weight_ready), 1);
      end
      if (dp_pixel_ready && obuf_wr_valid) overlap_cnt++;
      if (wbuf_rd_req && wbuf_rd_valid) begin
        wfetch_cnt++;
        if (exp_of_q.size() == 0) check("wbuf_fetch_unexpected", longint'(wbuf_of), -1);
        else check("wbuf_of", longint'(wbuf_of), longint'(exp_of_q.pop_front()));
      end
      if (pbuf_rd_req && pbuf_rd_valid) begin
        pfetch_cnt++;
        if (exp_tile_q.size() == 0) check("pbuf_fetch_unexpected", longint'({pbuf_ty, pbuf_tx}), -1);
        else check("pbuf_ty_tx", longint'({pbuf_ty, pbuf_tx}), longint'(exp_tile_q.pop_front()));
      end
      if (obuf_wr_valid) run++;
      if (obuf_wr_valid && obuf_wr_ready) begin
        store_cnt++;
        if (obuf_addr == 4'd5) addr5_run = run;
        run = 0;
        if (exp_addr_q.size() == 0) check("store_unexpected", longint'(obuf_addr), -1);
        else check("obuf_addr", longint'(obuf_addr), longint'(exp_addr_q.pop_front()));
      end
    end
  end

  // Job j: tx=j%2, ty=(j/2)%2, of=j/4 -> obuf_addr=j, {ty,tx}=j%4.
  task automatic layer_begin(input bit push);
    s_issue = issue_cnt; s_done = done_cnt; s_store = store_cnt;
    s_wf = wfetch_cnt; s_pf = pfetch_cnt; s_ovl = overlap_cnt;
    if (push) begin
      for (int o = 0; o < 4; o++) exp_of_q.push_back(o);
      for (int j = 0; j < 16; j++) begin
        exp_addr_q.push_back(j);
        exp_tile_q.push_back(j % 4);
      end
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic layer_end(input string name, input bit poke);
    int i;
    i = 0;
    while (!done && i < 6000) begin @(negedge clk); i++; end
    check({name, "_done_seen"}, longint'(done), 1);
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_start_on_done_ignored"}, longint'(busy), 0);
    end
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt - s_done, 1);
    check({name, "_stores"}, store_cnt - s_store, 16);
    check({name, "_wfetches"}, wfetch_cnt - s_wf, 4);
    check({name, "_pfetches"}, pfetch_cnt - s_pf, 16);
    check({name, "_busy_after"}, longint'(busy), 0);
    check({name, "_sb_left"}, exp_addr_q.size() + exp_of_q.size() + exp_tile_q.size(), 0);
    check({name, "_issue_during_store"}, overlap_cnt - s_ovl, 0);
  endtask

  task automatic wait_issues(input string name, input int target);
    int i;
    i = 0;
    while (issue_cnt < target && i < 3000) begin @(negedge clk); i++; end
    check(name, longint'(issue_cnt >= target), 1);
  endtask

  initial begin : global_timeout
    repeat (90000) @(posedge clk);
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", longint'(out_vec()), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Normal layer.
    layer_begin(1'b1);
    layer_end("normal", 1'b0);
    check("normal_err", longint'(err), 0);

    // Backpressure on job 5: valid + addr 5 held 21 cycles.
    stall_addr = 5; stall_len = 20;
    layer_begin(1'b1);
    layer_end("stall", 1'b0);
    check("stall_addr5_valid_cycles", addr5_run, 21);
    stall_addr = -1; stall_len = 0;

    // Watchdog on job 0: ISSUE, 154 WAIT cycles, err visible one cycle later.
    drop_job = 0;
    layer_begin(1'b1);
    k = 0;
    while (!dp_pixel_ready && k < 100) begin @(negedge clk); k++; end
    k = 0;
    while (!err && k < 400) begin @(negedge clk); k++; end
    check("wdog_err_latency", k, 155);
    check("wdog_store_pending", longint'(obuf_wr_valid), 1);
    layer_end("timeout", 1'b0);
    check("timeout_err_sticky", longint'(err), 1);
    drop_job = -1;

    // start while busy at job 3 is ignored; accepted start cleared err.
    layer_begin(1'b1);
    check("restart_err_cleared", longint'(err), 0);
    wait_issues("restart_reach_job3", s_issue + 4);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    layer_end("restart", 1'b0);

    // Reset during WAIT of job 7 abandons the layer.
    layer_begin(1'b1);
    wait_issues("midreset_reach_job7", s_issue + 8);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", longint'(out_vec()), 0);
    exp_addr_q.delete(); exp_of_q.delete(); exp_tile_q.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_no_done", done_cnt - s_done, 0);
    layer_begin(1'b1);
    layer_end("post_reset", 1'b0);

    // Spurious dp_acc_valid in IDLE sets err; next start clears it.
    check("spur_pre_err", longint'(err), 0);
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_err_set", longint'(err), 1);
    layer_begin(1'b1);
    check("spur_err_cleared", longint'(err), 0);
    layer_end("spur_layer", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
